mem_port_arbiter: RTL and testbench



---
 rtl/lc3b_types.sv | 37 +++
 rtl/mem_port_arbiter_if.sv | 31 +++
 rtl/mem_req_mux.sv | 38 +++
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b type package: data word, byte mask, memory request bundle and
// the arbiter state / port encodings used by mem_port_arbiter.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_A  = 2'd1,
        BUSY_B  = 2'd2,
        RECOVER = 2'd3
    } lc3b_arb_state;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } lc3b_arb_port;

    // One memory request as presented by a port or held on the shared bus.
    typedef struct packed {
        logic          read;
        logic          write;
        lc3b_mem_wmask wmask;
        lc3b_word      address;
        lc3b_word      wdata;
    } lc3b_mem_req;

    // A request where both strobes are high is carried out as a write only.
    function automatic lc3b_mem_req resolve_strobes(input lc3b_mem_req req);
        lc3b_mem_req r;
        r      = req;
        r.read = req.read & ~req.write;
        return r;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// LC-3b memory port bundle. Used three times around the arbiter: fetch port,
// data port and the shared physical memory bus.
//
// Handshake: the master raises read or write together with wmask, address and
// wdata and holds all of them unchanged until it sees resp=1 for one cycle;
// rdata is valid only in that resp cycle. There is no separate ready: resp is
// both the acceptance and the completion of the transfer.
interface mem_port_arbiter_if;
    import lc3b_types::*;

    logic          read;
    logic          write;
    lc3b_mem_wmask wmask;
    lc3b_word      address;
    lc3b_word      wdata;
    logic          resp;
    lc3b_word      rdata;

    // Requester side.
    modport master (
        output read, write, wmask, address, wdata,
        input  resp, rdata
    );

    // Responder side.
    modport slave (
        input  read, write, wmask, address, wdata,
        output resp, rdata
    );

endinterface

// File: rtl/mem_req_mux.sv
// Selects the request fields of port a or port b by the grant select. Pure
// combinational; its output is captured by the arbiter's pmem registers.
module mem_req_mux
    import lc3b_types::*;
(
    input  lc3b_arb_port  sel,
    input  logic          a_read,
    input  logic          a_write,
    input  lc3b_mem_wmask a_wmask,
    input  lc3b_word      a_address,
    input  lc3b_word      a_wdata,
    input  logic          b_read,
    input  logic          b_write,
    input  lc3b_mem_wmask b_wmask,
    input  lc3b_word      b_address,
    input  lc3b_word      b_wdata,
    output lc3b_mem_req   req
);

    // Pick the granted port's request bundle.
    always_comb begin
        req = '0;
        if (sel == PORT_B) begin
            req.read    = b_read;
            req.write   = b_write;
            req.wmask   = b_wmask;
            req.address = b_address;
            req.wdata   = b_wdata;
        end else begin
            req.read    = a_read;
            req.write   = a_write;
            req.wmask   = a_wmask;
            req.address = a_address;
            req.wdata   = a_wdata;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: fetch port (a) and data port (b) share one
// physical memory / cache bus. One port is granted at a time, its request is
// registered onto the shared bus, and resp/rdata go back to that port only.
// After each completed transfer one RECOVER cycle lets the finished requester
// drop or change its request so a stale request is never reissued.
//
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN -- on a tie the grant goes to
// the port not granted last time; without it the data port always wins ties.
module mem_port_arbiter
    import lc3b_types::*;
(
    input  logic          clk,
    input  logic          reset_n,
    mem_port_arbiter_if.slave  a,
    mem_port_arbiter_if.slave  b,
    mem_port_arbiter_if.master pmem,
    output lc3b_arb_state state_dbg
);

    lc3b_arb_state state;
    lc3b_arb_port  grant_sel;
    lc3b_mem_req   sel_req;
    lc3b_mem_req   issue_req;
    logic          a_req;
    logic          b_req;

    logic          pmem_read_q;
    logic          pmem_write_q;
    lc3b_mem_wmask pmem_wmask_q;
    lc3b_word      pmem_address_q;
    lc3b_word      pmem_wdata_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    lc3b_arb_port  last_grant;
`endif

    assign a_req = a.read | a.write;
    assign b_req = b.read | b.write;

    // Grant decision used in IDLE: tie-break is fixed or alternating.
    always_comb begin
        grant_sel = PORT_A;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (a_req && b_req) begin
            grant_sel = (last_grant == PORT_A) ? PORT_B : PORT_A;
        end else if (b_req) begin
            grant_sel = PORT_B;
        end
`else
        if (b_req) begin
            grant_sel = PORT_B;
        end
`endif
    end

    mem_req_mux u_req_mux (
        .sel       (grant_sel),
        .a_read    (a.read),
        .a_write   (a.write),
        .a_wmask   (a.wmask),
        .a_address (a.address),
        .a_wdata   (a.wdata),
        .b_read    (b.read),
        .b_write   (b.write),
        .b_wmask   (b.wmask),
        .b_address (b.address),
        .b_wdata   (b.wdata),
        .req       (sel_req)
    );

    assign issue_req = resolve_strobes(sel_req);

    // Arbitration FSM and the registered shared-bus request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_wmask_q   <= '0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant     <= PORT_A;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        state          <= (grant_sel == PORT_B) ? BUSY_B : BUSY_A;
                        pmem_read_q    <= issue_req.read;
                        pmem_write_q   <= issue_req.write;
                        pmem_wmask_q   <= issue_req.wmask;
                        pmem_address_q <= issue_req.address;
                        pmem_wdata_q   <= issue_req.wdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_grant     <= grant_sel;
`endif
                    end
                end
                BUSY_A, BUSY_B: begin
                    if (pmem.resp) begin
                        state        <= RECOVER;
                        pmem_read_q  <= 1'b0;
                        pmem_write_q <= 1'b0;
                    end
                end
                RECOVER: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign pmem.read    = pmem_read_q;
    assign pmem.write   = pmem_write_q;
    assign pmem.wmask   = pmem_wmask_q;
    assign pmem.address = pmem_address_q;
    assign pmem.wdata   = pmem_wdata_q;

    // Response goes only to the port that owns the bus; rdata is broadcast.
    assign a.resp  = (state == BUSY_A) & pmem.resp;
    assign b.resp  = (state == BUSY_B) & pmem.resp;
    assign a.rdata = pmem.rdata;
    assign b.rdata = pmem.rdata;

    assign state_dbg = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two requester drivers, a latency-programmable
// memory model on the shared bus, and a monitor that pops expected bus issues
// and per-port responses from queues filled by the directed test sequence.
module tb_mem_port_arbiter;
    import lc3b_types::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if a_bus ();
    mem_port_arbiter_if b_bus ();
    mem_port_arbiter_if pmem_bus ();
    lc3b_arb_state state_dbg;

    mem_port_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .a         (a_bus),
        .b         (b_bus),
        .pmem      (pmem_bus),
        .state_dbg (state_dbg)
    );

    logic     model_resp = 1'b0;
    logic     spur_resp = 1'b0;
    lc3b_word model_rdata = '0;
    assign pmem_bus.resp  = model_resp | spur_resp;
    assign pmem_bus.rdata = model_rdata;

    int mem_latency = 2;
    int mem_cnt = 0;
    int checks = 0;
    int failures = 0;

    logic [35:0] exp_issue_q[$];
    logic [15:0] exp_a_q[$];
    logic [15:0] exp_b_q[$];

    function automatic logic [35:0] pk(input logic rd, input logic wr, input logic [1:0] wm,
                                       input logic [15:0] addr, input logic [15:0] wd);
        return {rd, wr, wm, addr, wd};
    endfunction

    function automatic logic [15:0] rdata_fn(input logic [15:0] addr);
        if (addr == 16'h0040) return 16'h1234;
        return addr ^ 16'hA5A5;
    endfunction

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Memory model: answers after mem_latency cycles of a held strobe.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                mem_cnt    = 0;
                model_resp = 1'b0;
            end else if (model_resp) begin
                model_resp = 1'b0;
                mem_cnt    = 0;
            end else if (pmem_bus.read || pmem_bus.write) begin
                mem_cnt++;
                if (mem_cnt >= mem_latency) begin
                    model_resp  = 1'b1;
                    model_rdata = rdata_fn(pmem_bus.address);
                end
            end
        end
    end

    // Monitor / scoreboard.
    logic        prev_strobe = 1'b0;
    logic        after_resp = 1'b0;
    int          low_cnt = 0;
    logic [35:0] cur_issue = '0;
    initial begin
        logic        strobe;
        logic [35:0] now_issue;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_strobe = 1'b0;
                after_resp  = 1'b0;
                low_cnt     = 0;
            end else begin
                strobe    = pmem_bus.read | pmem_bus.write;
                now_issue = pk(pmem_bus.read, pmem_bus.write, pmem_bus.wmask,
                               pmem_bus.address, pmem_bus.wdata);
                if (strobe && !prev_strobe) begin
                    if (after_resp) chk("strobe_gap_ge2", 36'(low_cnt >= 2), 36'd1);
                    if (exp_issue_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL issue_unexpected actual=%h expected=none", now_issue);
                    end else begin
                        chk("issue", now_issue, exp_issue_q.pop_front());
                    end
                    cur_issue = now_issue;
                end else if (strobe) begin
                    chk("issue_stable", now_issue, cur_issue);
                end
                low_cnt = strobe ? 0 : low_cnt + 1;
                chk("resp_exclusive", 36'(a_bus.resp & b_bus.resp), 36'd0);
                if (a_bus.resp) begin
                    if (exp_a_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL a_resp_unexpected actual=1 expected=0");
                    end else begin
                        chk("a_rdata", 36'(a_bus.rdata), 36'(exp_a_q.pop_front()));
                    end
                end
                if (b_bus.resp) begin
                    if (exp_b_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL b_resp_unexpected actual=1 expected=0");
                    end else begin
                        chk("b_rdata", 36'(b_bus.rdata), 36'(exp_b_q.pop_front()));
                    end
                end
                if (a_bus.resp || b_bus.resp) after_resp = 1'b1;
                prev_strobe = strobe;
            end
        end
    end

    task automatic wait_resp(input bit is_b, input string name);
        bit got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = is_b ? b_bus.resp : a_bus.resp;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_resp expected=resp", name);
        end
    endtask

    // Raise a request, hold it until resp, drop it in the following cycle.
    task automatic port_txn(input bit is_b, input logic rd, input logic wr, input logic [1:0] wm,
                            input logic [15:0] addr, input logic [15:0] wd);
        if (is_b) begin
            b_bus.read = rd; b_bus.write = wr; b_bus.wmask = wm;
            b_bus.address = addr; b_bus.wdata = wd;
        end else begin
            a_bus.read = rd; a_bus.write = wr; a_bus.wmask = wm;
            a_bus.address = addr; a_bus.wdata = wd;
        end
        wait_resp(is_b, is_b ? "b_txn" : "a_txn");
        @(posedge clk);
        #1;
        if (is_b) begin
            b_bus.read = 1'b0; b_bus.write = 1'b0;
        end else begin
            a_bus.read = 1'b0; a_bus.write = 1'b0;
        end
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        a_bus.read = 0; a_bus.write = 0; a_bus.wmask = 0; a_bus.address = 0; a_bus.wdata = 0;
        b_bus.read = 0; b_bus.write = 0; b_bus.wmask = 0; b_bus.address = 0; b_bus.wdata = 0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pmem_read", 36'(pmem_bus.read), 36'd0);
        chk("rst_pmem_write", 36'(pmem_bus.write), 36'd0);
        chk("rst_pmem_wmask", 36'(pmem_bus.wmask), 36'd0);
        chk("rst_pmem_address", 36'(pmem_bus.address), 36'd0);
        chk("rst_pmem_wdata", 36'(pmem_bus.wdata), 36'd0);
        chk("rst_a_resp", 36'(a_bus.resp), 36'd0);
        chk("rst_b_resp", 36'(b_bus.resp), 36'd0);
        chk("rst_state", 36'(state_dbg), 36'(IDLE));
        reset_n = 1'b1;
        settle();

        // Ties: b issues two writes back to back, a two reads.
        mem_latency = 2;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_issue_q.push_back(pk(1'b0, 1'b1, 2'b01, 16'h0100, 16'hBEEF));
        exp_issue_q.push_back(pk(1'b1, 1'b0, 2'b00, 16'h0080, 16'h0000));
        exp_issue_q.push_back(pk(1'b0, 1'b1, 2'b10, 16'h0104, 16'hCAFE));
        exp_issue_q.push_back(pk(1'b1, 1'b0, 2'b00, 16'h0084, 16'h0000));
`else
        exp_issue_q.push_back(pk(1'b0, 1'b1, 2'b01, 16'h0100, 16'hBEEF));
        exp_issue_q.push_back(pk(1'b0, 1'b1, 2'b10, 16'h0104, 16'hCAFE));
        exp_issue_q.push_back(pk(1'b1, 1'b0, 2'b00, 16'h0080, 16'h0000));
        exp_issue_q.push_back(pk(1'b1, 1'b0, 2'b00, 16'h0084, 16'h0000));
`endif
        exp_b_q.push_back(16'hA4A5);
        exp_b_q.push_back(16'hA4A1);
        exp_a_q.push_back(16'hA525);
        exp_a_q.push_back(16'hA521);
        fork
            begin
                port_txn(1'b1, 1'b0, 1'b1, 2'b01, 16'h0100, 16'hBEEF);
                port_txn(1'b1, 1'b0, 1'b1, 2'b10, 16'h0104, 16'hCAFE);
            end
            begin
                port_txn(1'b0, 1'b1, 1'b0, 2'b00, 16'h0080, 16'h0000);
                port_txn(1'b0, 1'b1, 1'b0, 2'b00, 16'h0084, 16'h0000);
            end
        join
        settle();

        // Single read on port a, 3-cycle memory; grant latency and trailing gap.
        mem_latency = 3;
        exp_issue_q.push_back(pk(1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000));
        exp_a_q.push_back(16'h1234);
        a_bus.read = 1'b1; a_bus.wmask = 2'b00; a_bus.address = 16'h0040; a_bus.wdata = 16'h0000;
        @(negedge clk);
        chk("grant_not_before_edge", 36'(pmem_bus.read), 36'd0);
        @(negedge clk);
        chk("grant_after_edge", 36'(pmem_bus.read), 36'd1);
        chk("state_busy_a", 36'(state_dbg), 36'(BUSY_A));
        wait_resp(1'b0, "a_single");
        @(posedge clk);
        #1;
        a_bus.read = 1'b0;
        @(negedge clk);
        chk("read_low_recover", 36'(pmem_bus.read), 36'd0);
        chk("state_recover", 36'(state_dbg), 36'(RECOVER));
        @(negedge clk);
        chk("read_low_idle", 36'(pmem_bus.read), 36'd0);
        chk("state_idle", 36'(state_dbg), 36'(IDLE));
        settle();

        // Both strobes on port b: write only; then a stray resp in RECOVER.
        mem_latency = 2;
        exp_issue_q.push_back(pk(1'b0, 1'b1, 2'b11, 16'h0200, 16'h1111));
        exp_b_q.push_back(16'hA7A5);
        port_txn(1'b1, 1'b1, 1'b1, 2'b11, 16'h0200, 16'h1111);
        spur_resp = 1'b1;
        @(negedge clk);
        chk("recover_spur_a_resp", 36'(a_bus.resp), 36'd0);
        chk("recover_spur_b_resp", 36'(b_bus.resp), 36'd0);
        @(posedge clk);
        #1;
        spur_resp = 1'b0;
        settle();

        // Stray resp while IDLE.
        spur_resp = 1'b1;
        @(negedge clk);
        chk("idle_spur_a_resp", 36'(a_bus.resp), 36'd0);
        chk("idle_spur_b_resp", 36'(b_bus.resp), 36'd0);
        @(posedge clk);
        #1;
        spur_resp = 1'b0;
        @(negedge clk);
        chk("idle_spur_state", 36'(state_dbg), 36'(IDLE));
        settle();

        // Single-cycle memory, continuous port b reads.
        mem_latency = 1;
        for (int i = 0; i < 4; i++) begin
            exp_issue_q.push_back(pk(1'b1, 1'b0, 2'b00, 16'h0300 + 16'(i), 16'h0000));
        end
        exp_b_q.push_back(16'hA6A5);
        exp_b_q.push_back(16'hA6A4);
        exp_b_q.push_back(16'hA6A7);
        exp_b_q.push_back(16'hA6A6);
        for (int i = 0; i < 4; i++) begin
            port_txn(1'b1, 1'b1, 1'b0, 2'b00, 16'h0300 + 16'(i), 16'h0000);
        end
        settle();

        // Reset in the middle of a port b transaction.
        mem_latency = 10;
        exp_issue_q.push_back(pk(1'b1, 1'b0, 2'b00, 16'h0400, 16'h0000));
        b_bus.read = 1'b1; b_bus.wmask = 2'b00; b_bus.address = 16'h0400; b_bus.wdata = 16'h0000;
        for (int i = 0; i < 20 && state_dbg != BUSY_B; i++) @(negedge clk);
        chk("midrst_reached_busy_b", 36'(state_dbg), 36'(BUSY_B));
        repeat (2) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_pmem_read", 36'(pmem_bus.read), 36'd0);
        chk("midrst_pmem_write", 36'(pmem_bus.write), 36'd0);
        chk("midrst_a_resp", 36'(a_bus.resp), 36'd0);
        chk("midrst_b_resp", 36'(b_bus.resp), 36'd0);
        chk("midrst_state", 36'(state_dbg), 36'(IDLE));
        b_bus.read = 1'b0;
        mem_latency = 2;
        exp_issue_q.push_back(pk(1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000));
        exp_a_q.push_back(16'h1234);
        a_bus.read = 1'b1; a_bus.wmask = 2'b00; a_bus.address = 16'h0040; a_bus.wdata = 16'h0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        wait_resp(1'b0, "a_after_reset");
        @(posedge clk);
        #1;
        a_bus.read = 1'b0;
        settle();

        // Everything expected must have been seen.
        chk("issue_q_drained", 36'(exp_issue_q.size()), 36'd0);
        chk("a_q_drained", 36'(exp_a_q.size()), 36'd0);
        chk("b_q_drained", 36'(exp_b_q.size()), 36'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
